mdu_seq: RTL and testbench



---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_addsub.sv | 15 +
 rtl/mdu_seq.sv | 166 ++++++++++++++++
 tb/tb_mdu_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Optional build macro MDU_ABORT_EN is consumed by mdu_seq.
package mdu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ITER        = XLEN;
  localparam int unsigned CNT_W       = $clog2(ITER);
  localparam int unsigned MDU_LATENCY = 34;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_FIX_LO = 3'd2,
    S_FIX_HI = 3'd3,
    S_DONE   = 3'd4
  } mdu_state_e;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? XLEN'(~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// Shared 32-bit adder/subtractor: sum = a + (b ^ {sub}) + cin.
module mdu_addsub
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  input  logic            cin,
  output logic [XLEN-1:0] sum,
  output logic            cout
);

  assign {cout, sum} = (XLEN+1)'(a) + (XLEN+1)'(b ^ {XLEN{sub}}) + (XLEN+1)'(cin);

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULTU/MULT/DIVU/DIV sequencer: shift-add multiply, restoring divide,
// sign fixup on magnitudes. Define MDU_ABORT_EN to add the abort input.
module mdu_seq
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
`ifdef MDU_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_by_zero
);

  mdu_state_e state, state_next;

  logic [XLEN-1:0]  opa, opb, raw_a, acc_hi, acc_lo;
  logic [CNT_W-1:0] cnt;
  logic             div_q, neg_q, neg_r, dz, fix_carry;

  logic [XLEN-1:0]  add_x, add_y, add_sum, rem_sh;
  logic             add_sub, add_cin, add_cout, div_ok, abort_req;

`ifdef MDU_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Divide: partial remainder shifted left with the next dividend bit; a set
  // top bit means the 33-bit value already exceeds any divisor.
  assign rem_sh = {acc_hi[XLEN-2:0], opa[XLEN-1]};
  assign div_ok = acc_hi[XLEN-1] | add_cout;

  mdu_addsub u_addsub (
    .a    (add_x),
    .b    (add_y),
    .sub  (add_sub),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state and adder operand steering.
  always_comb begin
    state_next = state;
    add_x      = acc_hi;
    add_y      = '0;
    add_sub    = 1'b0;
    add_cin    = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        if (div_q) begin
          add_x   = rem_sh;
          add_y   = opb;
          add_sub = 1'b1;
          add_cin = 1'b1;
        end else begin
          add_x = acc_hi;
          add_y = opa;
        end
        if (cnt == CNT_W'(ITER-1)) state_next = S_FIX_LO;
      end
      S_FIX_LO: begin
        add_x      = ~acc_lo;
        add_cin    = 1'b1;
        state_next = S_FIX_HI;
      end
      S_FIX_HI: begin
        add_x      = ~acc_hi;
        add_cin    = div_q ? 1'b1 : fix_carry;
        state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort_req && (state == S_RUN || state == S_FIX_LO || state == S_FIX_HI))
      state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      raw_a       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      cnt         <= '0;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      fix_carry   <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
      done <= (state_next == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          opa         <= mag(a, op[0]);
          opb         <= mag(b, op[0]);
          raw_a       <= a;
          div_q       <= op[1];
          neg_q       <= op[0] & (a[XLEN-1] ^ b[XLEN-1]);
          neg_r       <= op[0] & a[XLEN-1];
          dz          <= (mdu_op_e'(op) == DIVU || mdu_op_e'(op) == DIV) && (b == '0);
          acc_hi      <= '0;
          acc_lo      <= '0;
          cnt         <= '0;
          fix_carry   <= 1'b0;
          div_by_zero <= 1'b0;
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (div_q) begin
            opa    <= {opa[XLEN-2:0], 1'b0};
            acc_hi <= div_ok ? add_sum : rem_sh;
            acc_lo <= {acc_lo[XLEN-2:0], div_ok};
          end else begin
            opb <= {1'b0, opb[XLEN-1:1]};
            if (opb[0]) begin
              acc_hi <= {add_cout, add_sum[XLEN-1:1]};
              acc_lo <= {add_sum[0], acc_lo[XLEN-1:1]};
            end else begin
              acc_hi <= {1'b0, acc_hi[XLEN-1:1]};
              acc_lo <= {acc_hi[0], acc_lo[XLEN-1:1]};
            end
          end
        end
        S_FIX_LO: if (neg_q) begin
          acc_lo    <= add_sum;
          fix_carry <= add_cout;
        end
        S_FIX_HI: if (state_next == S_DONE) begin
          if (dz) begin
            hi <= raw_a;
            lo <= '1;
          end else begin
            hi <= (div_q ? neg_r : neg_q) ? add_sum : acc_hi;
            lo <= acc_lo;
          end
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vectors, random ops against an
// arithmetic reference model, start/reset robustness, optional abort.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dz;
  logic [31:0] hi, lo;
`ifdef MDU_ABORT_EN
  logic        abort;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
`ifdef MDU_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (dz)
  );

  // Reference: {div_by_zero, hi, lo} from plain 64-bit / signed arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0]        p;
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    p  = '0;
    case (o)
      2'd0: p = {32'd0, x} * {32'd0, y};
      2'd1: p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 2'd2) p = {x % y, x / y};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else p = {32'(sx % sy), 32'(sx / sy)};
      end
    endcase
    return {1'b0, p};
  endfunction

  // Drive one operation; optionally pulse start again at cycle ign_at.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int ign_at, output int lat, output logic [31:0] rh,
                        output logic [31:0] rl, output logic rdz, output logic held,
                        output logic bz_ok, output logic bz_after, output logic dn_after);
    logic [31:0] ph, pl;
    ph = hi;
    pl = lo;
    held  = 1'b1;
    bz_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) bz_ok = 1'b0;
      if (hi !== ph || lo !== pl) held = 1'b0;
      @(posedge clk); #1;
      lat++;
      start = (lat == ign_at);
    end
    rh  = hi;
    rl  = lo;
    rdz = dz;
    if (busy !== 1'b1) bz_ok = 1'b0;
    @(posedge clk); #1;
    start    = 1'b0;
    bz_after = busy;
    dn_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
`ifdef MDU_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, dz, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, expected all zero", busy, done, dz, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [7] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3};
    logic [31:0] t_a  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'd2, 32'h8000_0000};
    logic [31:0] t_b  [7] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd7, 32'd0, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] t_hi [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h1234, 32'd0, 32'd0};
    logic [31:0] t_lo [7] = '{32'h1, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'd6, 32'h8000_0000};
    logic        t_dz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [31:0] rh, rl;
    logic rdz, held, bz_ok, bz_after, dn_after;
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], -1, lat, rh, rl, rdz, held, bz_ok, bz_after, dn_after);
      checks++;
      if (lat !== 34 || rh !== t_hi[i] || rl !== t_lo[i] || rdz !== t_dz[i]) begin
        errors++;
        $display("FAIL directed_%0d: lat=%0d hi=%h lo=%h dz=%b, expected lat=34 hi=%h lo=%h dz=%b",
                 i, lat, rh, rl, rdz, t_hi[i], t_lo[i], t_dz[i]);
      end
      checks++;
      if (!bz_ok || bz_after !== 1'b0 || dn_after !== 1'b0) begin
        errors++;
        $display("FAIL directed_handshake_%0d: busy_during=%b busy_after=%b done_after=%b, expected 1 0 0",
                 i, bz_ok, bz_after, dn_after);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [31:0] rh, rl;
    logic rdz, held, bz_ok, bz_after, dn_after;
    logic [64:0] exp;
    // Start pulse in the middle of RUN.
    exp = model(2'd3, 32'hDEAD_BEEF, 32'h0000_1235);
    run_op(2'd3, 32'hDEAD_BEEF, 32'h0000_1235, 10, lat, rh, rl, rdz, held, bz_ok, bz_after, dn_after);
    checks++;
    if (lat !== 34 || {rdz, rh, rl} !== exp || bz_after !== 1'b0) begin
      errors++;
      $display("FAIL start_mid_run: lat=%0d hi=%h lo=%h dz=%b busy_after=%b, expected lat=34 hi=%h lo=%h dz=%b busy_after=0",
               lat, rh, rl, rdz, bz_after, exp[63:32], exp[31:0], exp[64]);
    end
    // Start pulse during the DONE cycle.
    exp = model(2'd1, 32'h7FFF_FFFF, 32'h8000_0000);
    run_op(2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 34, lat, rh, rl, rdz, held, bz_ok, bz_after, dn_after);
    checks++;
    if (lat !== 34 || {rdz, rh, rl} !== exp || bz_after !== 1'b0 || dn_after !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: lat=%0d hi=%h lo=%h busy_after=%b done_after=%b, expected lat=34 hi=%h lo=%h busy_after=0 done_after=0",
               lat, rh, rl, bz_after, dn_after, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic [31:0] rh, rl;
    logic rdz, held, bz_ok, bz_after, dn_after, seen;
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, dz, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b dz=%b hi=%h lo=%h, expected all zero", busy, done, dz, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_done: activity after reset abort = %b, expected 0", seen);
    end
    run_op(2'd2, 32'd100, 32'd7, -1, lat, rh, rl, rdz, held, bz_ok, bz_after, dn_after);
    checks++;
    if (lat !== 34 || rh !== 32'd2 || rl !== 32'd14 || rdz !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op: lat=%0d hi=%h lo=%h dz=%b, expected lat=34 hi=2 lo=e dz=0", lat, rh, rl, rdz);
    end
  endtask

  task automatic test_random_back_to_back();
    int lat;
    logic [31:0] rh, rl, x, y;
    logic [1:0]  o;
    logic rdz, held, bz_ok, bz_after, dn_after;
    logic [64:0] exp;
    for (int i = 0; i < 48; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF;
        3: x = 32'h8000_0000;
        4: x = 32'd0;
        default: ;
      endcase
      exp = model(o, x, y);
      run_op(o, x, y, -1, lat, rh, rl, rdz, held, bz_ok, bz_after, dn_after);
      checks++;
      if (lat !== 34 || {rdz, rh, rl} !== exp) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h dz=%b, expected lat=34 hi=%h lo=%h dz=%b",
                 i, o, x, y, lat, rh, rl, rdz, exp[63:32], exp[31:0], exp[64]);
      end
      checks++;
      if (!held || !bz_ok || bz_after !== 1'b0 || dn_after !== 1'b0) begin
        errors++;
        $display("FAIL random_handshake_%0d: hold=%b busy_during=%b busy_after=%b done_after=%b, expected 1 1 0 0",
                 i, held, bz_ok, bz_after, dn_after);
      end
    end
  endtask

`ifdef MDU_ABORT_EN
  task automatic test_abort();
    logic [31:0] ph, pl;
    logic seen;
    ph = hi;
    pl = lo;
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'h1357_9BDF; b = 32'h2468_ACE0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== ph || lo !== pl) begin
      errors++;
      $display("FAIL abort_idle: busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h", busy, hi, lo, ph, pl);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: done seen = %b, expected 0", seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_op();
    test_random_back_to_back();
`ifdef MDU_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
